// File: rtl/rr_arb8.sv
// rr_arb8: eight-way round-robin arbiter with bounded grant tenure.
// Ports: clock, reset_n (sync, active-low), req[7:0], en -> gnt[7:0], gnt_idx[2:0], gnt_valid, expired.
module rr_arb8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] req,
  input  logic       en,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       expired
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state, state_n;
  logic [2:0]      owner, owner_n;
  logic [2:0]      ptr, ptr_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [7:0]      gnt_q, gnt_n;
  logic            exp_q, exp_n;

  logic [3:0]      pick_idle;
  logic [3:0]      pick_next;
  logic [2:0]      below;
  logic            own_req;
  logic            done;

  // {found, index}: nearest set bit scanning down from 'from', wrapping.
  // Walk farthest-first so the nearest hit is the last write.
  function automatic logic [3:0] pick(
    input logic [7:0] r,
    input logic [2:0] from
  );
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      idx = from - 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign below     = owner - 3'd1;
  assign own_req   = req[owner];
  assign done      = !own_req || (hold_cnt == LAST);
  assign pick_idle = pick(req, ptr);
  // Search from owner-1 so the current owner comes last.
  assign pick_next = pick(req, below);

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    gnt_n   = gnt_q;
    exp_n   = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_n = 8'h00;
        if (en && pick_idle[3]) begin
          state_n = GRANT;
          owner_n = pick_idle[2:0];
          gnt_n   = 8'h01 << pick_idle[2:0];
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (!en) begin
          state_n = IDLE;
          gnt_n   = 8'h00;
        end else if (done) begin
          // Release outranks expiry, so only flag a true timeout.
          exp_n = own_req;
          ptr_n = below;
          if (pick_next[3]) begin
            owner_n = pick_next[2:0];
            gnt_n   = 8'h01 << pick_next[2:0];
            hold_n  = '0;
          end else begin
            state_n = IDLE;
            gnt_n   = 8'h00;
          end
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      owner    <= 3'd0;
      ptr      <= 3'd7;
      hold_cnt <= '0;
      gnt_q    <= 8'h00;
      exp_q    <= 1'b0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      gnt_q    <= gnt_n;
      exp_q    <= exp_n;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = (state == GRANT);
  assign gnt_idx   = gnt_valid ? owner : 3'd0;
  assign expired   = exp_q;

endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8: random plus directed stimulus on two arbiters
// (MAX_HOLD 4 and 1) checked against a behavioural model.
module tb_rr_arb8;

  logic       clock;
  logic       reset_n;
  logic [7:0] req;
  logic       en;

  logic [7:0] gnt0, gnt1;
  logic [2:0] idx0, idx1;
  logic       val0, val1;
  logic       exp0, exp1;

  int n_tests;
  int n_fail;

  int m_own[2];
  int m_ptr[2];
  int m_held[2];
  int m_exp[2];
  int m_max[2];

  rr_arb8 #(.MAX_HOLD(4)) dut0 (
    .clock(clock), .reset_n(reset_n), .req(req), .en(en),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(val0), .expired(exp0)
  );

  rr_arb8 #(.MAX_HOLD(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req(req), .en(en),
    .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(val1), .expired(exp1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int from);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (from - k + 8) % 8;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Model: m_own<0 means no grant; m_held counts cycles the grant has been visible.
  task automatic model_step(input int u);
    m_exp[u] = 0;
    if (!reset_n) begin
      m_own[u]  = -1;
      m_ptr[u]  = 7;
      m_held[u] = 0;
    end else if (m_own[u] < 0) begin
      if (en && req != 8'h00) begin
        m_own[u]  = pick(req, m_ptr[u]);
        m_held[u] = 1;
      end
    end else if (!en) begin
      m_own[u]  = -1;
      m_held[u] = 0;
    end else begin
      bit rel, tmo;
      int w;
      rel = !req[m_own[u]];
      tmo = (m_held[u] == m_max[u]);
      if (rel || tmo) begin
        m_exp[u]  = rel ? 0 : 1;
        m_ptr[u]  = (m_own[u] + 7) % 8;
        w         = pick(req, m_ptr[u]);
        m_own[u]  = w;
        m_held[u] = (w >= 0) ? 1 : 0;
      end else begin
        m_held[u]++;
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] eg;
    for (int u = 0; u < 2; u++) begin
      eg = (m_own[u] < 0) ? 8'h00 : 8'(1 << m_own[u]);
      if (u == 0) begin
        chk("gnt0", 32'(gnt0), 32'(eg));
        chk("idx0", 32'(idx0), (m_own[u] < 0) ? 0 : m_own[u]);
        chk("val0", 32'(val0), (m_own[u] < 0) ? 0 : 1);
        chk("exp0", 32'(exp0), m_exp[u]);
      end else begin
        chk("gnt1", 32'(gnt1), 32'(eg));
        chk("idx1", 32'(idx1), (m_own[u] < 0) ? 0 : m_own[u]);
        chk("val1", 32'(val1), (m_own[u] < 0) ? 0 : 1);
        chk("exp1", 32'(exp1), m_exp[u]);
      end
    end
  endtask

  task automatic cyc(input logic r_n, input logic e, input logic [7:0] r);
    reset_n = r_n;
    en      = e;
    req     = r;
    @(posedge clock);
    model_step(0);
    model_step(1);
    @(negedge clock);
    check_all();
  endtask

  logic [7:0] rot [12];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_max[0] = 4;
    m_max[1] = 1;
    reset_n = 1'b0;
    en      = 1'b1;
    req     = 8'hFF;
    @(negedge clock);

    cyc(1'b0, 1'b1, 8'hFF);
    chk("rst_gnt", 32'(gnt0), 32'h0);
    cyc(1'b0, 1'b1, 8'hFF);
    chk("rst_exp", 32'(exp0), 32'h0);
    cyc(1'b1, 1'b1, 8'hFF);
    chk("first_gnt", 32'(gnt0), 32'h80);

    rot = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h01, 8'h01,
            8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h80};
    cyc(1'b0, 1'b1, 8'h00);
    for (int j = 1; j <= 12; j++) begin
      cyc(1'b1, 1'b1, 8'h81);
      chk("rot_gnt", 32'(gnt0), 32'(rot[j-1]));
      chk("rot_exp", 32'(exp0), (j == 5 || j == 9) ? 1 : 0);
    end

    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 8'h24);
    cyc(1'b1, 1'b1, 8'h24);
    chk("rel_c2", 32'(gnt0), 32'h20);
    cyc(1'b1, 1'b1, 8'h04);
    chk("rel_c3", 32'(gnt0), 32'h04);
    chk("rel_exp", 32'(exp0), 32'h0);
    cyc(1'b1, 1'b1, 8'h04);

    cyc(1'b0, 1'b1, 8'h00);
    for (int j = 1; j <= 16; j++) begin
      cyc(1'b1, 1'b1, 8'hFF);
      chk("fair_idx", 32'(idx1), 7 - ((j - 1) % 8));
    end

    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 8'h08);
    cyc(1'b1, 1'b1, 8'h08);
    cyc(1'b1, 1'b0, 8'h08);
    chk("en_off", 32'(gnt0), 32'h0);
    cyc(1'b1, 1'b0, 8'h08);
    cyc(1'b1, 1'b1, 8'h08);
    chk("en_back", 32'(gnt0), 32'h08);

    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 8'h10);
    cyc(1'b1, 1'b1, 8'h10);
    cyc(1'b1, 1'b1, 8'h10);
    cyc(1'b0, 1'b1, 8'h10);
    chk("midrst", 32'(gnt0), 32'h0);
    cyc(1'b1, 1'b1, 8'h90);
    chk("post_rst", 32'(gnt0), 32'h80);

    for (int j = 0; j < 3000; j++) begin
      logic [7:0] r;
      logic e, rn;
      r  = 8'($urandom);
      if ($urandom_range(3) == 0) r = r & 8'($urandom);
      e  = ($urandom_range(15) != 0);
      rn = ($urandom_range(99) != 0);
      cyc(rn, e, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
